// File: rtl/conv3x3_stream_engine_pkg.sv
// Shared types and arithmetic helpers for the 3x3 streaming convolution engine.
// Holds the FSM encoding, accumulator sizing and the shift/saturate/ReLU stage.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int TAPS = 9;

   function automatic int acc_w(input int data_w);
      return 2 * data_w + 4;
   endfunction

   // Arithmetic shift, clamp to the signed data_w range, then optional ReLU.
   function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                    input int shift,
                                                    input int data_w,
                                                    input logic relu);
      logic signed [63:0] sh;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      logic signed [63:0] res;
      sh    = acc >>> shift;
      max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (data_w - 1));
      if (sh > max_v) begin
         res = max_v;
      end else if (sh < min_v) begin
         res = min_v;
      end else begin
         res = sh;
      end
      if (relu && (res < 64'sd0)) begin
         return 64'sd0;
      end else begin
         return res;
      end
   endfunction

endpackage

// File: rtl/conv3x3_stream_engine_mac_ch.sv
// One output channel: nine signed products, a balanced adder tree and the
// shift/saturate stage. Purely combinational; the top registers the result.
module conv3x3_mac_ch
   import conv_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int SHIFT  = 0,
   parameter int RELU   = 0
) (
   input  logic [TAPS*DATA_W-1:0] win,
   input  logic [TAPS*DATA_W-1:0] wt,
   output logic [DATA_W-1:0]      result
);

   localparam int ACC_W = acc_w(DATA_W);

   logic signed [ACC_W-1:0] prod   [TAPS];
   logic signed [ACC_W-1:0] sum_l1 [4];
   logic signed [ACC_W-1:0] sum_l2 [2];
   logic signed [ACC_W-1:0] acc;

   // Sign-extend both operands to ACC_W so the low product bits are exact.
   always_comb begin
      for (int t = 0; t < TAPS; t++) begin
         prod[t] = ACC_W'($signed(win[t*DATA_W +: DATA_W])) *
                   ACC_W'($signed(wt[t*DATA_W +: DATA_W]));
      end
      for (int i = 0; i < 4; i++) begin
         sum_l1[i] = prod[2*i] + prod[2*i+1];
      end
      sum_l2[0] = sum_l1[0] + sum_l1[1];
      sum_l2[1] = sum_l1[2] + sum_l1[3];
      acc       = sum_l2[0] + sum_l2[1] + prod[8];
      result    = DATA_W'(sat_shift(64'(acc), SHIFT, DATA_W, RELU != 0));
   end

endmodule

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 valid convolution: raster pixels in, one NUM_CH-wide word out
// per complete window, with a single pass-through output register.
module conv3x3_stream_engine
   import conv_pkg::*;
#(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int NUM_CH = 3,
   parameter int DATA_W = 8,
   parameter int SHIFT  = 0,
   parameter int RELU   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wt_valid,
   input  logic [DATA_W-1:0]        wt_data,
   output logic                     wt_loaded,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     frame_done
);

   localparam int LB_LEN = 2 * IMG_W + 3;
   localparam int WT_N   = TAPS * NUM_CH;
   localparam int WT_IW  = $clog2(WT_N);
   localparam int COL_W  = $clog2(IMG_W);
   localparam int ROW_W  = $clog2(IMG_H);

   state_t                    state_q, state_d;
   logic [WT_IW-1:0]          wt_idx_q, wt_idx_d;
   logic                      wt_loaded_q, wt_loaded_d;
   logic [COL_W-1:0]          col_q, col_d;
   logic [ROW_W-1:0]          row_q, row_d;
   logic                      out_valid_q, out_valid_d;
   logic [NUM_CH*DATA_W-1:0]  out_data_q, out_data_d;
   logic                      out_last_q, out_last_d;

   logic [DATA_W-1:0]         wt_mem_q [WT_N];
   logic [DATA_W-1:0]         lb_q     [LB_LEN];
   logic [DATA_W-1:0]         lb_d     [LB_LEN];
   logic                      wt_we;
   logic [WT_IW-1:0]          wt_addr;

   logic                      accept;
   logic                      out_hs;
   logic                      last_pix;
   logic                      win_done;
   logic [TAPS*DATA_W-1:0]    win_flat;
   logic [NUM_CH*DATA_W-1:0]  mac_res;

   assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
   assign accept     = in_valid && in_ready;
   assign out_hs     = out_valid_q && out_ready;
   assign last_pix   = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
   assign win_done   = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

   assign wt_loaded  = wt_loaded_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == DRAIN) && out_hs && out_last_q;

   // Weight write sequencing; a write after a full set starts a fresh set at index 0.
   always_comb begin
      wt_idx_d    = wt_idx_q;
      wt_loaded_d = wt_loaded_q;
      wt_we       = 1'b0;
      wt_addr     = wt_idx_q;
      if (wt_valid && (state_q == IDLE)) begin
         wt_we = 1'b1;
         if (wt_loaded_q) begin
            wt_addr     = {WT_IW{1'b0}};
            wt_idx_d    = WT_IW'(1);
            wt_loaded_d = 1'b0;
         end else if (wt_idx_q == WT_IW'(WT_N - 1)) begin
            wt_idx_d    = {WT_IW{1'b0}};
            wt_loaded_d = 1'b1;
         end else begin
            wt_idx_d    = wt_idx_q + WT_IW'(1);
         end
      end else begin
         wt_we = 1'b0;
      end
   end

   // Line buffer next state; the window is taken from the post-shift view so the
   // pixel being accepted is already at offset 0.
   always_comb begin
      lb_d = lb_q;
      if (accept) begin
         lb_d[0] = in_data;
         for (int i = 1; i < LB_LEN; i++) begin
            lb_d[i] = lb_q[i-1];
         end
      end else begin
         lb_d = lb_q;
      end
      win_flat = {(TAPS*DATA_W){1'b0}};
      for (int t = 0; t < TAPS; t++) begin
         win_flat[t*DATA_W +: DATA_W] = lb_d[(2 - t/3) * IMG_W + (2 - t%3)];
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [TAPS*DATA_W-1:0] wt_flat;
      for (genvar t = 0; t < TAPS; t++) begin : g_tap
         assign wt_flat[t*DATA_W +: DATA_W] = wt_mem_q[ch*TAPS + t];
      end
      conv3x3_mac_ch #(
         .DATA_W (DATA_W),
         .SHIFT  (SHIFT),
         .RELU   (RELU)
      ) u_mac (
         .win    (win_flat),
         .wt     (wt_flat),
         .result (mac_res[ch*DATA_W +: DATA_W])
      );
   end

   // FSM and raster position counters.
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      case (state_q)
         IDLE: begin
            if (start && wt_loaded_q) begin
               state_d = RUN;
               col_d   = {COL_W{1'b0}};
               row_d   = {ROW_W{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (accept) begin
               if (last_pix) begin
                  state_d = DRAIN;
                  col_d   = {COL_W{1'b0}};
                  row_d   = {ROW_W{1'b0}};
               end else if (col_q == COL_W'(IMG_W - 1)) begin
                  col_d   = {COL_W{1'b0}};
                  row_d   = row_q + ROW_W'(1);
               end else begin
                  col_d   = col_q + COL_W'(1);
               end
            end else begin
               state_d = RUN;
            end
         end
         DRAIN: begin
            if (out_hs && out_last_q) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output register: a new window overwrites, otherwise acceptance empties it.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      if (win_done) begin
         out_valid_d = 1'b1;
         out_data_d  = mac_res;
         out_last_d  = last_pix;
      end else if (out_hs) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wt_idx_q    <= {WT_IW{1'b0}};
         wt_loaded_q <= 1'b0;
         col_q       <= {COL_W{1'b0}};
         row_q       <= {ROW_W{1'b0}};
         out_valid_q <= 1'b0;
         out_data_q  <= {(NUM_CH*DATA_W){1'b0}};
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wt_idx_q    <= wt_idx_d;
         wt_loaded_q <= wt_loaded_d;
         col_q       <= col_d;
         row_q       <= row_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   // Weight store and line buffer carry no reset; their contents are rewritten before use.
   always_ff @(posedge clk) begin
      if (wt_we) begin
         wt_mem_q[wt_addr] <= wt_data;
      end
      lb_q <= lb_d;
   end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Scoreboard bench: expected windows are computed from the image in raster
// coordinates when each pixel is accepted and compared as outputs are taken.
module tb_conv3x3_stream_engine;

   localparam int W    = 8;
   localparam int H    = 8;
   localparam int NC   = 3;
   localparam int NPIX = W * H;
   localparam int NOUT = (W - 2) * (H - 2);

   logic        clk = 1'b0;
   logic        rst;
   logic        wt_valid;
   logic [7:0]  wt_data;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        out_ready;

   logic        wt_loaded, in_ready, out_valid, out_last, busy, frame_done;
   logic [23:0] out_data;
   logic        wt_loaded_r, in_ready_r, out_valid_r, out_last_r, busy_r, frame_done_r;
   logic [23:0] out_data_r;

   typedef struct {
      logic [23:0] d0;
      logic [23:0] d1;
      logic        last;
   } exp_t;

   exp_t              sb[$];
   logic signed [7:0] wts [27];
   logic signed [7:0] img [NPIX];
   int                checks   = 0;
   int                failures = 0;

   always #5 clk = ~clk;

   conv3x3_stream_engine #(.IMG_W(W), .IMG_H(H), .NUM_CH(NC), .DATA_W(8), .SHIFT(0), .RELU(0)) u_dut (
      .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_data(wt_data), .wt_loaded(wt_loaded),
      .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .frame_done(frame_done));

   conv3x3_stream_engine #(.IMG_W(W), .IMG_H(H), .NUM_CH(NC), .DATA_W(8), .SHIFT(0), .RELU(1)) u_dut_relu (
      .clk(clk), .rst(rst), .wt_valid(wt_valid), .wt_data(wt_data), .wt_loaded(wt_loaded_r),
      .start(start), .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
      .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r), .out_last(out_last_r),
      .busy(busy_r), .frame_done(frame_done_r));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] sat8(input int v, input bit relu);
      int s;
      s = v;
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      if (relu && s < 0) s = 0;
      return s[7:0];
   endfunction

   function automatic exp_t model(input int r, input int c);
      exp_t e;
      int   s;
      e.d0 = 24'h0;
      e.d1 = 24'h0;
      for (int ch = 0; ch < NC; ch++) begin
         s = 0;
         for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
               s += int'(img[(r - 2 + ky) * W + (c - 2 + kx)]) * int'(wts[ch*9 + ky*3 + kx]);
         e.d0[ch*8 +: 8] = sat8(s, 1'b0);
         e.d1[ch*8 +: 8] = sat8(s, 1'b1);
      end
      e.last = (r == H - 1) && (c == W - 1);
      return e;
   endfunction

   task automatic check_idle(input string tag);
      check_eq({tag, "_in_ready"},   in_ready,   1'b0);
      check_eq({tag, "_out_valid"},  out_valid,  1'b0);
      check_eq({tag, "_out_last"},   out_last,   1'b0);
      check_eq({tag, "_busy"},       busy,       1'b0);
      check_eq({tag, "_frame_done"}, frame_done, 1'b0);
      check_eq({tag, "_out_data"},   out_data,   24'h0);
      check_eq({tag, "_wt_loaded"},  wt_loaded,  1'b0);
      check_eq({tag, "_relu_valid"}, out_valid_r, 1'b0);
   endtask

   task automatic load_wts(input int n);
      for (int k = 0; k < n; k++) begin
         wt_valid = 1'b1;
         wt_data  = wts[k];
         @(negedge clk);
      end
      wt_valid = 1'b0;
   endtask

   // mode: 0 always ready, 1 five-cycle stall at first output, 2 random backpressure
   task automatic run_frame(input string tag, input int mode, input int abort_at);
      int          p = 0;
      int          nout = 0;
      int          stall_left = 0;
      bit          stall_done = 1'b0;
      bit          hs;
      bit          exp_fd;
      logic [23:0] held = 24'h0;
      exp_t        e;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq({tag, "_busy_start"}, busy, 1'b1);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (nout == NOUT) break;
         in_valid = (p < NPIX);
         in_data  = (p < NPIX) ? img[p] : 8'h00;
         if (mode == 1 && !stall_done && out_valid) begin
            stall_left = 5;
            stall_done = 1'b1;
            held       = out_data;
         end
         if (mode == 2) out_ready = ($urandom_range(0, 3) != 0);
         else           out_ready = (stall_left == 0);
         #1;
         if (stall_left > 0) begin
            check_eq({tag, "_stall_in_ready"},  in_ready,  1'b0);
            check_eq({tag, "_stall_out_valid"}, out_valid, 1'b1);
            check_eq({tag, "_stall_hold"},      out_data,  held);
            stall_left--;
         end
         hs     = out_valid && out_ready;
         exp_fd = 1'b0;
         if (hs) begin
            if (sb.size() == 0) begin
               check_eq({tag, "_unexpected_out"}, 1'b1, 1'b0);
            end else begin
               e = sb.pop_front();
               check_eq({tag, "_data"},      out_data,   e.d0);
               check_eq({tag, "_data_relu"}, out_data_r, e.d1);
               check_eq({tag, "_last"},      out_last,   e.last);
               exp_fd = e.last;
            end
            nout++;
         end
         check_eq({tag, "_frame_done"}, frame_done, exp_fd);
         if (in_valid && in_ready) begin
            if ((p / W) >= 2 && (p % W) >= 2) sb.push_back(model(p / W, p % W));
            p++;
         end
         if (abort_at > 0 && p == abort_at) break;
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (abort_at == 0) begin
         check_eq({tag, "_out_count"}, nout, NOUT);
         check_eq({tag, "_sb_empty"},  sb.size(), 0);
         check_eq({tag, "_busy_end"},  busy, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1; wt_valid = 1'b0; wt_data = 8'h00; start = 1'b0;
      in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      // all ones
      for (int k = 0; k < 27; k++) wts[k] = 8'sd1;
      for (int i = 0; i < NPIX; i++) img[i] = 8'sd1;
      load_wts(27);
      check_eq("ones_wt_loaded", wt_loaded, 1'b1);
      run_frame("ones", 0, 0);

      // saturation both ways, ReLU on the second instance
      for (int k = 0; k < 27; k++) wts[k] = (k < 9) ? 8'sd127 : ((k < 18) ? -8'sd127 : 8'sd0);
      for (int i = 0; i < NPIX; i++) img[i] = 8'sd127;
      load_wts(27);
      run_frame("sat", 0, 0);

      // ramp image, centre tap only, with a stall at the first output
      for (int k = 0; k < 27; k++) wts[k] = (k == 4) ? 8'sd1 : 8'sd0;
      for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
      load_wts(27);
      run_frame("ramp", 1, 0);

      // incomplete weight set blocks start
      for (int k = 0; k < 27; k++) wts[k] = 8'($urandom_range(0, 255));
      for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
      load_wts(26);
      check_eq("partial_wt_loaded", wt_loaded, 1'b0);
      in_valid = 1'b1;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check_eq("partial_busy", busy, 1'b0);
      check_eq("partial_in_ready", in_ready, 1'b0);
      in_valid = 1'b0;
      wt_valid = 1'b1;
      wt_data  = wts[26];
      @(negedge clk);
      wt_valid = 1'b0;
      check_eq("partial_wt_loaded_27", wt_loaded, 1'b1);
      run_frame("rand", 2, 0);

      // reset mid-frame, then reload and run again
      for (int k = 0; k < 27; k++) wts[k] = 8'($urandom_range(0, 255));
      for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
      load_wts(27);
      run_frame("abort", 0, 20);
      rst = 1'b1;
      @(negedge clk);
      check_idle("midrst");
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      load_wts(27);
      run_frame("after_rst", 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
